// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared types and defaults for the perceptron feeder
package perceptron_pkg;

  localparam int          DW_DEFAULT         = 16;
  localparam logic [15:0] BIAS_VALUE_DEFAULT = 16'h0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/perceptron_feeder_if.sv
// rtl/perceptron_feeder_if.sv - host write/control and sample stream signals of the feeder
interface perceptron_feeder_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          val_o;
  logic          rdy_i;

  // master: the feeder itself, sourcing the sample stream
  modport master (
    input  wr_en, wr_addr, wr_data, start, len, rdy_i,
    output busy, done, data_o, last_o, val_o
  );

  // slave: host plus downstream consumer
  modport slave (
    output wr_en, wr_addr, wr_data, start, len, rdy_i,
    input  busy, done, data_o, last_o, val_o
  );
endinterface

// File: rtl/perceptron_feeder_buf.sv
// rtl/perceptron_feeder_buf.sv - sample register file, synchronous write, asynchronous read
module perceptron_feeder_buf #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // host write port; contents deliberately have no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/perceptron_feeder.sv
// rtl/perceptron_feeder.sv - frame source streaming the sample buffer; PERCEPTRON_FEEDER_BIAS_EN prepends a bias sample
module perceptron_feeder
  import perceptron_pkg::*;
#(
  parameter int          DW         = DW_DEFAULT,
  parameter int          DEPTH      = 16,
  parameter int          AW         = $clog2(DEPTH),
  parameter logic [DW-1:0] BIAS_VALUE = DW'(BIAS_VALUE_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  perceptron_feeder_if.master bus
);

`ifdef PERCEPTRON_FEEDER_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);
  localparam logic [AW:0] TWO_L   = (AW+1)'(2);

  feeder_state_t state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   cnt;
  logic [AW:0]   len_c;
  logic          bias_q;
  logic [DW-1:0] rd_data;
  logic          hs;
  logic          buf_we;

  assign len_c  = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
  assign hs     = bus.val_o && bus.rdy_i;
  assign buf_we = bus.wr_en && (state == IDLE);

  // Prefetch address: entry 0 when starting or leaving the bias sample,
  // otherwise the entry after the one currently presented.
  assign rd_addr = (state == SEND && !bias_q) ? ptr + AW'(1) : '0;

  perceptron_feeder_buf #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Frame FSM with registered stream and status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      bias_q     <= 1'b0;
      bus.val_o  <= 1'b0;
      bus.last_o <= 1'b0;
      bus.data_o <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            ptr      <= '0;
            bus.busy <= 1'b1;
            if (BIAS_EN) begin
              cnt        <= len_c + ONE_L;
              bias_q     <= 1'b1;
              state      <= SEND;
              bus.val_o  <= 1'b1;
              bus.data_o <= BIAS_VALUE;
              bus.last_o <= (len_c == '0);
            end else if (len_c == '0) begin
              cnt      <= '0;
              state    <= FIN;
              bus.done <= 1'b1;
            end else begin
              cnt        <= len_c;
              state      <= SEND;
              bus.val_o  <= 1'b1;
              bus.data_o <= rd_data;
              bus.last_o <= (len_c == ONE_L);
            end
          end
        end
        SEND: begin
          if (hs) begin
            ptr    <= bias_q ? ptr : ptr + AW'(1);
            bias_q <= 1'b0;
            cnt    <= cnt - ONE_L;
            if (cnt == ONE_L) begin
              state      <= FIN;
              bus.val_o  <= 1'b0;
              bus.last_o <= 1'b0;
              bus.done   <= 1'b1;
            end else begin
              bus.data_o <= rd_data;
              bus.last_o <= (cnt == TWO_L);
            end
          end
        end
        FIN: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_feeder.sv
// tb/tb_perceptron_feeder.sv - directed self-checking bench for perceptron_feeder
module tb_perceptron_feeder;

  localparam int          DW    = 16;
  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [15:0] BIAS  = 16'h0100;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  perceptron_feeder_if #(.DW(DW), .AW(AW)) bus ();

  perceptron_feeder #(
    .DW         (DW),
    .DEPTH      (DEPTH),
    .AW         (AW),
    .BIAS_VALUE (BIAS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  logic [DW-1:0] exp_d [$];
  logic          exp_l [$];
  int first_val, done_at, done_cnt, stab_err;

  task automatic write_buf(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    mem_m[a]    = d;
  endtask

  task automatic build_expected(input int len_v);
    int n;
    n = (len_v > DEPTH) ? DEPTH : len_v;
    exp_d.delete();
    exp_l.delete();
`ifdef PERCEPTRON_FEEDER_BIAS_EN
    exp_d.push_back(BIAS);
    exp_l.push_back(n == 0);
`endif
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(mem_m[i]);
      exp_l.push_back(i == n - 1);
    end
  endtask

  // cycle (counted from the cycle after start) in which done should be seen
  function automatic int exp_done(input int mode);
    int n;
    n = exp_d.size();
    if (n == 0) return 1;
    return (mode == 0) ? n + 1 : 3 * n - 1;
  endfunction

  // mode 0: rdy always 1; mode 1: rdy 1,0,0,1,...
  // inject 1: second start mid-frame; inject 2: write mid-frame
  task automatic run_frame(input int len_v, input int mode, input int inject);
    int c, tail;
    logic rdy, prev_stall, prev_l;
    logic [DW-1:0] prev_d;
    got_d.delete();
    got_l.delete();
    first_val = -1; done_at = -1; done_cnt = 0; stab_err = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = (AW+1)'(len_v);
    bus.rdy_i = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1; tail = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    while (c < 300) begin
      if (prev_stall && (bus.val_o !== 1'b1 || bus.data_o !== prev_d || bus.last_o !== prev_l))
        stab_err++;
      if (bus.val_o === 1'b1 && first_val < 0) first_val = c;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      rdy         = (mode == 0) ? 1'b1 : ((c - 1) % 3 == 0);
      bus.rdy_i   = rdy;
      bus.start   = (inject == 1 && c == 2);
      bus.wr_en   = (inject == 2 && c == 2);
      bus.wr_addr = '0;
      bus.wr_data = 16'hDEAD;
      if (inject == 1 && c == 2) bus.len = (AW+1)'(1);
      if (bus.val_o === 1'b1 && rdy) begin
        got_d.push_back(bus.data_o);
        got_l.push_back(bus.last_o);
      end
      prev_stall = (bus.val_o === 1'b1) && !rdy;
      prev_d     = bus.data_o;
      prev_l     = bus.last_o;
      if (done_at >= 0) begin
        tail++;
        if (tail > 3) break;
      end
      @(negedge clk);
      c++;
    end
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    bus.rdy_i = 1'b0;
  endtask

  task automatic test_reset();
    int act;
    checks++; if (bus.val_o !== 1'b0) begin errors++; $display("FAIL reset_val got=%b exp=0", bus.val_o); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.last_o !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", bus.last_o); end
    checks++; if (bus.data_o !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", bus.data_o); end
    act = 0;
    bus.rdy_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.val_o !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) act++;
    end
    bus.rdy_i = 1'b0;
    checks++; if (act !== 0) begin errors++; $display("FAIL idle_activity got=%0d exp=0", act); end
  endtask

  task automatic test_full_throughput();
    for (int i = 0; i < 4; i++) write_buf(i, DW'(i + 1));
    build_expected(4);
    run_frame(4, 0, 0);
    checks++; if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL full_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL full_sample%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
    checks++; if (first_val !== 1) begin errors++; $display("FAIL full_latency got=%0d exp=1", first_val); end
    checks++; if (done_at !== exp_done(0)) begin errors++; $display("FAIL full_done_at got=%0d exp=%0d", done_at, exp_done(0)); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_width got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_back_pressure();
    build_expected(4);
    run_frame(4, 1, 0);
    checks++; if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL bp_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL bp_sample%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stability got=%0d exp=0", stab_err); end
    checks++; if (done_at !== exp_done(1)) begin errors++; $display("FAIL bp_done_at got=%0d exp=%0d", done_at, exp_done(1)); end
  endtask

  task automatic test_len_zero();
    build_expected(0);
    run_frame(0, 0, 0);
    checks++; if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL len0_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL len0_sample%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
    checks++; if (first_val !== ((exp_d.size() == 0) ? -1 : 1)) begin errors++; $display("FAIL len0_val got=%0d", first_val); end
    checks++; if (done_at !== exp_done(0)) begin errors++; $display("FAIL len0_done_at got=%0d exp=%0d", done_at, exp_done(0)); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL len0_done_width got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_len_clamp();
    for (int i = 0; i < DEPTH; i++) write_buf(i, 16'hA000 + DW'(i));
    build_expected(DEPTH + 5);
    run_frame(DEPTH + 5, 0, 0);
    checks++; if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL clamp_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL clamp_sample%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
    checks++; if (done_at !== exp_done(0)) begin errors++; $display("FAIL clamp_done_at got=%0d exp=%0d", done_at, exp_done(0)); end
  endtask

  task automatic test_restart_ignored();
    for (int i = 0; i < 4; i++) write_buf(i, 16'h0010 * DW'(i + 1));
    build_expected(4);
    run_frame(4, 0, 1);
    checks++; if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL restart_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin errors++; $display("FAIL restart_sample%0d got=%h/%b exp=%h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL restart_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_busy_write();
    run_frame(4, 0, 2);
    build_expected(4);
    run_frame(4, 0, 0);
    checks++; if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL busywr_count got=%0d exp=%0d", got_d.size(), exp_d.size()); end
    foreach (exp_d[i]) if (i < got_d.size()) begin
      checks++;
      if (got_d[i] !== exp_d[i]) begin errors++; $display("FAIL busywr_sample%0d got=%h exp=%h", i, got_d[i], exp_d[i]); end
    end
  endtask

  task automatic test_reset_abort();
    int dn, vl;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = (AW+1)'(4);
    bus.rdy_i = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    checks++; if (bus.val_o !== 1'b1) begin errors++; $display("FAIL abort_pre_val got=%b exp=1", bus.val_o); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.val_o !== 1'b0) begin errors++; $display("FAIL abort_val got=%b exp=0", bus.val_o); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.data_o !== 16'h0000) begin errors++; $display("FAIL abort_data got=%h exp=0000", bus.data_o); end
    @(negedge clk);
    reset     = 1'b0;
    bus.rdy_i = 1'b1;
    dn = 0; vl = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dn++;
      if (bus.val_o === 1'b1) vl++;
    end
    bus.rdy_i = 1'b0;
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", dn); end
    checks++; if (vl !== 0) begin errors++; $display("FAIL abort_post_val got=%0d exp=0", vl); end
  endtask

`ifdef PERCEPTRON_FEEDER_BIAS_EN
  task automatic test_bias();
    write_buf(0, 16'h1111);
    write_buf(1, 16'h2222);
    run_frame(2, 0, 0);
    checks++; if (got_d.size() != 3) begin errors++; $display("FAIL bias_count got=%0d exp=3", got_d.size()); end
    if (got_d.size() == 3) begin
      checks++; if (got_d[0] !== 16'h0100 || got_l[0] !== 1'b0) begin errors++; $display("FAIL bias_s0 got=%h/%b exp=0100/0", got_d[0], got_l[0]); end
      checks++; if (got_d[1] !== 16'h1111 || got_l[1] !== 1'b0) begin errors++; $display("FAIL bias_s1 got=%h/%b exp=1111/0", got_d[1], got_l[1]); end
      checks++; if (got_d[2] !== 16'h2222 || got_l[2] !== 1'b1) begin errors++; $display("FAIL bias_s2 got=%h/%b exp=2222/1", got_d[2], got_l[2]); end
    end
    checks++; if (done_at !== 4) begin errors++; $display("FAIL bias_done_at got=%0d exp=4", done_at); end
  endtask
`endif

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.len     = '0;
    bus.rdy_i   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_full_throughput();
    test_back_pressure();
    test_len_zero();
    test_len_clamp();
    test_restart_ignored();
    test_busy_write();
    test_reset_abort();
`ifdef PERCEPTRON_FEEDER_BIAS_EN
    test_bias();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/perceptron_feeder.md
# perceptron_feeder

Transmit-side stream source for the perceptron network. It holds one feature vector in a small local sample buffer, written by the host. On a start command it streams the vector, one sample per handshake, into the perceptron pipeline's `val_i`/`rdy_o` input port. It drives `val_o`/`data_o`/`last_o` and obeys `rdy_i` back-pressure, using the same valid/ready rules as the perceptron control path.

## Interface
- `DW`, 16: sample width in bits.
- `DEPTH`, 16: buffer entries; power of two, at least 2.
- `AW`, $clog2(DEPTH): buffer address width.
- `BIAS_VALUE`, 16'h0100: constant bias sample (Q8.8 1.0); used only when `PERCEPTRON_FEEDER_BIAS_EN` is defined.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `wr_en` in 1: host buffer write strobe.
- `wr_addr` in AW: write address.
- `wr_data` in DW: write data.
- `start` in 1: begin a frame (single-cycle pulse).
- `len` in AW+1: number of samples in the frame, 0..DEPTH.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when a frame completes.
- `data_o` out DW: sample presented downstream.
- `last_o` out 1: marks the final sample of a frame.
- `val_o` out 1: output valid.
- `rdy_i` in 1: downstream ready; comes from the perceptron `rdy_o`.

## Operation
- States are IDLE, SEND and FIN.
- IDLE:
  - `wr_en` writes `wr_data` into `buf[wr_addr]` at the clock edge.
  - `start` latches `len` into the remaining-count register `cnt` and clears the read pointer `ptr`.
  - If `len`≠0, go to SEND. If `len`=0, go to FIN.
  - A `len` value greater than DEPTH is clamped to DEPTH.
- SEND:
  - `val_o`=1, `data_o`=`buf[ptr]`, `last_o`=(`cnt`==1).
  - A handshake is `val_o`&&`rdy_i` at a clock edge. On each handshake, `ptr`++ and `cnt`--.
  - The handshake on the `last_o` sample moves the block to FIN.
- FIN: `done`=1 for exactly one cycle, then return to IDLE.
- `busy`=1 in SEND and FIN.
- While `busy`=1:
  - `wr_en` is ignored and the buffer is unchanged.
  - `start` is ignored.
- Output stability: while `val_o`=1 and `rdy_i`=0, `data_o` and `last_o` hold their values. `val_o` never drops without a handshake.
- `ptr` never wraps within a frame, because `cnt` is at most DEPTH.

## Timing
- Reset values: `val_o`=0, `last_o`=0, `data_o`=0, `busy`=0, `done`=0, state=IDLE, `ptr`=0, `cnt`=0. Buffer contents are not reset.
- Reset asserted mid-frame aborts the frame immediately. Outputs go to their reset values asynchronously, and no `done` pulse is produced.
- Outputs are registered. The buffer read is combinational from `ptr`, and the sample is registered into `data_o`.
- Start latency: `start` sampled at edge t gives `val_o`=1 and `data_o`=`buf[0]` from edge t+1.
- Throughput is one sample per cycle when `rdy_i` is held high. A handshake at edge k presents the next sample from edge k.
- `done` is asserted in the cycle after the final handshake.
- `start` is accepted again in the cycle after `done`.
- `len`=0: `done` is asserted at t+1. `val_o` never rises.
- A write in the same cycle as `start` is accepted. It is visible to the frame if the written address is read later than the cycle of the write.

## Configuration
- `PERCEPTRON_FEEDER_BIAS_EN` defined:
  - Every frame first emits one extra sample equal to `BIAS_VALUE` (bias input), with `last_o`=0, then the `len` buffer samples.
  - With `len`=0, the bias sample alone is emitted with `last_o`=1, and `done` follows its handshake.
  - A frame therefore contains `len`+1 handshakes.
- Not defined: no bias sample, and `BIAS_VALUE` is unused.

## Structure
- Shared package `perceptron_pkg` holds:
  - the state enum (IDLE/SEND/FIN);
  - the default `DW`;
  - the `BIAS_VALUE` default constant.
- One sub-module, `perceptron_feeder_buf`: a DEPTH×DW register file with a synchronous write port and an asynchronous read port.
- The FSM, counters and output register stay in the top module.

## Test plan
- Reset then idle: after reset, `val_o`=0, `busy`=0, `done`=0. No output activity for 20 cycles.
- Full-throughput frame: write `buf[i]`=i+1 for i=0..3, `len`=4, `rdy_i`=1.
  - Expected: data 1,2,3,4 on 4 consecutive cycles starting at t+1, with `last_o` only on 4.
  - Expected: `done` pulses one cycle after the sample 4 handshake.
- Back-pressure: same frame with `rdy_i` toggling 1,0,0,1,…
  - Each sample is held stable through the stall cycles.
  - No sample is lost or duplicated; 4 handshakes in total.
- Edge cases for `len`:
  - `len`=0: `done` at t+1 and no `val_o`.
  - `len`=DEPTH+5: clamped to DEPTH, so DEPTH samples are emitted.
  - A second `start` mid-frame is ignored.
- Busy write and reset abort:
  - `wr_en` during SEND leaves the buffer unchanged; check with a later frame.
  - `reset` asserted mid-frame gives `val_o`=0 immediately and no `done`.
- With `PERCEPTRON_FEEDER_BIAS_EN`:
  - `len`=2 gives the sequence 16'h0100, buf[0], buf[1], with `last_o` on buf[1].
  - `len`=0 gives 16'h0100 alone with `last_o`=1.
